// File: rtl/cmd_sequencer_if.sv
// Fetch/datapath <-> cmd_sequencer handshake bundle.
// master: fetch unit and datapath side; slave: the sequencer.
`timescale 1ns/1ps
interface cmd_sequencer_if #(
    parameter int NSRC     = 2,
    parameter int REG_BITS = 4,
    parameter int DATA_W   = 32
);
    localparam int CMD_W = (NSRC + 2) * (REG_BITS + 3);

    logic             start;
    logic [CMD_W-1:0] cmd;
    logic [DATA_W-1:0] cond;
    logic             step_ack;
    logic [3:0]       state;
    logic [2:0]       opnd;
    logic             busy;
    logic             done;
    logic             skipped;

    modport master (
        output start, cmd, cond, step_ack,
        input  state, opnd, busy, done, skipped
    );

    modport slave (
        input  start, cmd, cond, step_ack,
        output state, opnd, busy, done, skipped
    );
endinterface

// File: rtl/cmd_sequencer.sv
// Instruction-phase sequencer: latches a command and walks the datapath phases.
// Optional CMDSEQ_WB_DEDUP_EN: one WRITE per register number (src0 > ... > dst).
`timescale 1ns/1ps
module cmd_sequencer #(
    parameter int                  NSRC     = 2,
    parameter int                  REG_BITS = 4,
    parameter int                  DATA_W   = 32,
    parameter logic [REG_BITS-1:0] IP_REG   = '1
) (
    input logic           clk,
    input logic           rst,
    cmd_sequencer_if.slave bus
);
    localparam int NS    = NSRC + 2;
    localparam int SW    = REG_BITS + 3;
    localparam int CMD_W = NS * SW;
    localparam int NP    = NSRC + 1;

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        PREEXEC     = 4'd1,
        WRITE_IP    = 4'd2,
        READ        = 4'd3,
        READ_P      = 4'd4,
        ALU_BEGIN   = 4'd5,
        ALU_RESULTS = 4'd6,
        WRITE_PREP  = 4'd7,
        WRITE       = 4'd8,
        FINISH      = 4'd9
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       opnd_q, opnd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             skipped_q, skipped_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;

    logic [NS-1:0]       used, ptr, wbf, writer, ip_hit, wr_ok;
    logic [REG_BITS-1:0] regn [NS];
    logic [7:0]          ptr8;
    logic [NP-1:0]       rd_need, wr_need;
    logic                ip_wr, cond_zero;

    for (genvar s = 0; s < NS; s++) begin : g_slot
        assign used[s]   = cmd_q[s*SW+REG_BITS+1 +: 2] != 2'b11;
        assign ptr[s]    = cmd_q[s*SW+REG_BITS];
        assign wbf[s]    = ^cmd_q[s*SW+REG_BITS+1 +: 2];
        assign regn[s]   = cmd_q[s*SW +: REG_BITS];
        assign writer[s] = used[s] && (s == 1 || (s >= 2 && wbf[s]));
        assign ip_hit[s] = regn[s] == IP_REG;
    end

    // A writer loses its WRITE when a higher-priority writer shares its reg.
    always_comb begin
        wr_ok = writer;
`ifdef CMDSEQ_WB_DEDUP_EN
        for (int s = 1; s < NS; s++) begin
            for (int t = 2; t < NS; t++) begin
                if (writer[t] && regn[t] == regn[s] && (s == 1 || t < s))
                    wr_ok[s] = 1'b0;
            end
        end
`endif
    end

    // Position 0 is cond (reads) or dst (writes); then src NSRC-1 .. src0.
    for (genvar p = 0; p < NP; p++) begin : g_pos
        assign rd_need[p] = used[p == 0 ? 0 : NS - p];
        assign wr_need[p] = wr_ok[p == 0 ? 1 : NS - p];
    end

    assign ptr8      = 8'(ptr);
    assign ip_wr     = |(writer & ip_hit);
    assign cond_zero = bus.cond == '0;

    function automatic logic [3:0] first_at(
        input logic [NP-1:0] need,
        input int            lo
    );
        logic [3:0] r;
        r = '0;
        for (int p = NP - 1; p >= 0; p--) begin
            if (p >= lo && need[p]) r = {1'b1, 3'(p)};
        end
        return r;
    endfunction

    function automatic logic [2:0] rslot(input logic [2:0] p);
        return (p == 3'd0) ? 3'd0 : 3'(NS - int'(p));
    endfunction

    function automatic logic [2:0] wslot(input logic [2:0] p);
        return (p == 3'd0) ? 3'd1 : 3'(NS - int'(p));
    endfunction

    int         rpos_nx, wpos_nx;
    logic [3:0] rsel, wsel;
    state_e     rd_st, wr_st;
    logic [2:0] rd_op, wr_op;

    assign rpos_nx = (opnd_q == 3'd0) ? 1 : NS - int'(opnd_q) + 1;
    assign wpos_nx = (opnd_q == 3'd1) ? 1 : NS - int'(opnd_q) + 1;

    always_comb begin
        rsel = (state_q == READ || state_q == READ_P)
             ? first_at(rd_need, rpos_nx) : first_at(rd_need, 0);
        wsel = (state_q == WRITE)
             ? first_at(wr_need, wpos_nx) : first_at(wr_need, 0);
        rd_st = rsel[3] ? READ : ALU_BEGIN;
        rd_op = rsel[3] ? rslot(rsel[2:0]) : 3'd0;
        wr_st = wsel[3] ? WRITE : FINISH;
        wr_op = wsel[3] ? wslot(wsel[2:0]) : 3'd0;
    end

    always_comb begin
        state_d   = state_q;
        opnd_d    = '0;
        skipped_d = skipped_q;
        cmd_d     = cmd_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = PREEXEC;
                    cmd_d     = bus.cmd;
                    skipped_d = 1'b0;
                end
            end
            PREEXEC: begin
                if (!ip_wr) begin
                    state_d = WRITE_IP;
                end else begin
                    state_d = rd_st;
                    opnd_d  = rd_op;
                end
            end
            WRITE_IP: begin
                if (bus.step_ack) begin
                    state_d = rd_st;
                    opnd_d  = rd_op;
                end
            end
            READ: begin
                opnd_d = opnd_q;
                if (bus.step_ack) begin
                    if (ptr8[opnd_q]) begin
                        state_d = READ_P;
                    end else if (opnd_q == 3'd0 && cond_zero) begin
                        state_d   = FINISH;
                        opnd_d    = '0;
                        skipped_d = 1'b1;
                    end else begin
                        state_d = rd_st;
                        opnd_d  = rd_op;
                    end
                end
            end
            READ_P: begin
                opnd_d = opnd_q;
                if (bus.step_ack) begin
                    if (opnd_q == 3'd0 && cond_zero) begin
                        state_d   = FINISH;
                        opnd_d    = '0;
                        skipped_d = 1'b1;
                    end else begin
                        state_d = rd_st;
                        opnd_d  = rd_op;
                    end
                end
            end
            ALU_BEGIN:   state_d = ALU_RESULTS;
            ALU_RESULTS: state_d = WRITE_PREP;
            WRITE_PREP: begin
                state_d = wr_st;
                opnd_d  = wr_op;
            end
            WRITE: begin
                opnd_d = opnd_q;
                if (bus.step_ack) begin
                    state_d = wr_st;
                    opnd_d  = wr_op;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
        done_d = state_d == FINISH;
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            opnd_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            skipped_q <= 1'b0;
            cmd_q     <= '1;
        end else begin
            state_q   <= state_d;
            opnd_q    <= opnd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            skipped_q <= skipped_d;
            cmd_q     <= cmd_d;
        end
    end

    assign bus.state   = state_q;
    assign bus.opnd    = opnd_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.skipped = skipped_q;
endmodule

// File: tb/tb_cmd_sequencer.sv
// Bench for cmd_sequencer: phase-list model plus literal traces.
// Trace entries are encoded as state*8 + opnd.
`timescale 1ns/1ps
module tb_cmd_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cmd_sequencer_if #(.NSRC(2), .REG_BITS(4), .DATA_W(32)) bus2 ();
    cmd_sequencer_if #(.NSRC(4), .REG_BITS(4), .DATA_W(32)) bus4 ();

    cmd_sequencer #(
        .NSRC(2), .REG_BITS(4), .DATA_W(32), .IP_REG(4'hF)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus2.slave)
    );

    cmd_sequencer #(
        .NSRC(4), .REG_BITS(4), .DATA_W(32), .IP_REG(4'hF)
    ) dut4 (
        .clk(clk), .rst(rst), .bus(bus4.slave)
    );

    assign bus4.step_ack = 1'b1;

    localparam logic [6:0] UN = 7'h7F;

    typedef struct packed {
        logic [3:0] st;
        logic [2:0] op;
        logic       sk;
    } ph_t;

    int  checks = 0;
    int  errors = 0;
    ph_t expq[$];
    ph_t cur;
    bit  chk_en = 0;
    int  trace[$];
    int  exp_t[$];
    int  prev_v;
    bit  rec = 0;
    bit  pre_skip;
    int  trace4[$];
    int  done_cnt;
    bit  rec4 = 0;

    function automatic ph_t mk(input int st, input int op, input bit sk);
        ph_t p;
        p.st = st[3:0];
        p.op = op[2:0];
        p.sk = sk;
        return p;
    endfunction

    function automatic logic [6:0] sl(
        input logic [1:0] f, input logic p, input logic [3:0] r
    );
        return {f, p, r};
    endfunction

    function automatic logic [27:0] cmd2(
        input logic [6:0] c, input logic [6:0] d,
        input logic [6:0] s0, input logic [6:0] s1
    );
        return {s1, s0, d, c};
    endfunction

    function automatic bit is_wait(input logic [3:0] st);
        return st == 4'd2 || st == 4'd3 || st == 4'd4 || st == 4'd8;
    endfunction

    function automatic bit is_writer(input logic [6:0] x, input int i);
        return x[6:5] != 2'b11 && (i == 1 || x[6] != x[5]);
    endfunction

    function automatic int rank(input int i);
        return (i == 1) ? 99 : i;
    endfunction

    // Expected phase list of one instruction on the NSRC=2 instance.
    function automatic void build(input logic [27:0] c, input logic [31:0] cv);
        logic [6:0] s [4];
        bit ipw;
        bit keep;
        int k;
        int rd [3];
        int wo [3];
        for (int i = 0; i < 4; i++) s[i] = c[i*7 +: 7];
        expq.push_back(mk(1, 0, 0));
        ipw = 0;
        for (int i = 1; i < 4; i++)
            if (is_writer(s[i], i) && s[i][3:0] == 4'hF) ipw = 1;
        if (!ipw) expq.push_back(mk(2, 0, 0));
        rd = '{0, 3, 2};
        for (int j = 0; j < 3; j++) begin
            k = rd[j];
            if (s[k][6:5] != 2'b11) begin
                expq.push_back(mk(3, k, 0));
                if (s[k][4]) expq.push_back(mk(4, k, 0));
                if (k == 0 && cv == 0) begin
                    expq.push_back(mk(9, 0, 1));
                    return;
                end
            end
        end
        expq.push_back(mk(5, 0, 0));
        expq.push_back(mk(6, 0, 0));
        expq.push_back(mk(7, 0, 0));
        wo = '{1, 3, 2};
        for (int j = 0; j < 3; j++) begin
            k = wo[j];
            if (is_writer(s[k], k)) begin
                keep = 1;
`ifdef CMDSEQ_WB_DEDUP_EN
                for (int m = 1; m < 4; m++)
                    if (m != k && is_writer(s[m], m) &&
                        s[m][3:0] == s[k][3:0] && rank(m) < rank(k))
                        keep = 0;
`endif
                if (keep) expq.push_back(mk(8, k, 0));
            end
        end
        expq.push_back(mk(9, 0, 0));
    endfunction

    function automatic ph_t next_ph();
        if (expq.size() > 0) return expq.pop_front();
        return mk(0, 0, cur.sk);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (cur.st == 4'd0) begin
                if (bus2.start) cur = next_ph();
            end else if (!is_wait(cur.st) || bus2.step_ack) begin
                if (cur.st == 4'd9) cur = mk(0, 0, cur.sk);
                else cur = next_ph();
            end
        end
    end

    always @(posedge clk) begin
        if (chk_en && !rst) begin
            checks++;
            if (bus2.state !== cur.st || bus2.opnd !== cur.op ||
                bus2.busy !== (cur.st != 0) || bus2.done !== (cur.st == 9) ||
                bus2.skipped !== cur.sk) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t got st=%0d op=%0d busy=%0b done=%0b skip=%0b want st=%0d op=%0d skip=%0b",
                         $time, bus2.state, bus2.opnd, bus2.busy, bus2.done,
                         bus2.skipped, cur.st, cur.op, cur.sk);
            end
        end
    end

    always @(posedge clk) begin
        int v;
        if (rec) begin
            v = int'(bus2.state) * 8 + int'(bus2.opnd);
            if (v != prev_v) begin
                trace.push_back(v);
                if (bus2.state == 4'd1) pre_skip = bus2.skipped;
            end
            prev_v = v;
        end
        if (rec4) begin
            if (bus4.busy) trace4.push_back(int'(bus4.state) * 8 + int'(bus4.opnd));
            if (bus4.done) done_cnt++;
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic check_trace(input string nm, input int got[$]);
        bit ok;
        int bad;
        ok = got.size() == exp_t.size();
        bad = -1;
        if (ok)
            for (int i = 0; i < got.size(); i++)
                if (got[i] != exp_t[i] && bad < 0) bad = i;
        checks++;
        if (!ok || bad >= 0) begin
            errors++;
            if (!ok)
                $display("FAIL %s got_len=%0d want_len=%0d", nm, got.size(), exp_t.size());
            else
                $display("FAIL %s idx=%0d got=%0d want=%0d", nm, bad, got[bad], exp_t[bad]);
        end
    endtask

    task automatic run(input logic [27:0] c, input logic [31:0] cv, input int gap);
        int n;
        build(c, cv);
        trace.delete();
        prev_v = 0;
        pre_skip = 1;
        rec = 1;
        @(posedge clk); #1;
        bus2.cmd = c;
        bus2.cond = cv;
        bus2.start = 1;
        bus2.step_ack = 0;
        @(posedge clk); #1;
        bus2.start = 0;
        n = 0;
        while (cur.st != 4'd0 && n < 300) begin
            bus2.step_ack = (gap == 0) ? 1'b1 : ($urandom_range(0, gap) == 0);
            @(posedge clk); #1;
            n++;
        end
        bus2.step_ack = 0;
        rec = 0;
        chk("run_timeout", int'(n >= 300), 0);
    endtask

    logic [27:0] tbl [4];

    initial begin
        int n;
        cur = mk(0, 0, 0);
        bus2.start = 0;
        bus2.step_ack = 0;
        bus2.cmd = '1;
        bus2.cond = '0;
        bus4.start = 0;
        bus4.cmd = '1;
        bus4.cond = 32'd9;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", bus2.state, 0);
        chk("rst_busy", bus2.busy, 0);
        rst = 0;
        chk_en = 1;
        @(posedge clk); #1;
        chk("rst_opnd", bus2.opnd, 0);
        chk("rst_done", bus2.done, 0);
        chk("rst_skipped", bus2.skipped, 0);

        run(cmd2(UN, sl(2'b00, 0, 3), sl(2'b00, 0, 2), sl(2'b00, 0, 1)), 32'd1, 2);
        exp_t = '{8, 16, 27, 26, 40, 48, 56, 65, 72, 0};
        check_trace("seq_dst3", trace);

        run(cmd2(sl(2'b00, 1, 4), sl(2'b00, 0, 3), sl(2'b00, 0, 1), UN), 32'd0, 1);
        exp_t = '{8, 16, 24, 32, 72, 0};
        check_trace("cond_ptr_skip", trace);
        repeat (2) @(posedge clk);
        #1;
        chk("skip_held", bus2.skipped, 1);

        run(cmd2(sl(2'b00, 0, 0), UN, UN, sl(2'b10, 1, 7)), 32'd5, 2);
        exp_t = '{8, 16, 24, 27, 35, 40, 48, 56, 67, 72, 0};
        check_trace("cond_ok_src_ptr", trace);
        chk("skip_cleared", int'(pre_skip), 0);

        run(cmd2(sl(2'b00, 0, 6), sl(2'b00, 0, 2), UN, UN), 32'd0, 0);
        exp_t = '{8, 16, 24, 72, 0};
        check_trace("cond_direct_zero", trace);

        run(cmd2(UN, sl(2'b00, 0, 5), sl(2'b01, 0, 5), UN), 32'd1, 1);
`ifdef CMDSEQ_WB_DEDUP_EN
        exp_t = '{8, 16, 26, 40, 48, 56, 66, 72, 0};
`else
        exp_t = '{8, 16, 26, 40, 48, 56, 65, 66, 72, 0};
`endif
        check_trace("wb_dup_reg5", trace);

        // Abort an instruction parked in READ with an asynchronous reset.
        build(cmd2(UN, UN, sl(2'b00, 0, 1), UN), 32'd1);
        @(posedge clk); #1;
        bus2.cmd = cmd2(UN, UN, sl(2'b00, 0, 1), UN);
        bus2.start = 1;
        @(posedge clk); #1;
        bus2.start = 0;
        n = 0;
        while (cur.st != 4'd3 && n < 20) begin
            bus2.step_ack = (cur.st == 4'd2);
            @(posedge clk); #1;
            n++;
        end
        bus2.step_ack = 0;
        @(posedge clk); #1;
        chk("pre_rst_read", bus2.state, 3);
        #1;
        rst = 1;
        bus2.step_ack = 1;
        cur = mk(0, 0, 0);
        expq.delete();
        #1;
        chk("async_rst_state", bus2.state, 0);
        chk("async_rst_busy", bus2.busy, 0);
        #1;
        rst = 0;
        @(posedge clk); #1;
        bus2.step_ack = 0;

        run(cmd2(UN, sl(2'b00, 0, 15), sl(2'b00, 0, 2), UN), 32'd1, 2);
        exp_t = '{8, 26, 40, 48, 56, 65, 72, 0};
        check_trace("dst_ip_after_rst", trace);

        tbl[0] = cmd2(UN, UN, UN, UN);
        tbl[1] = cmd2(sl(2'b01, 1, 9), sl(2'b00, 1, 15), sl(2'b10, 1, 15), sl(2'b01, 0, 15));
        tbl[2] = cmd2(sl(2'b00, 1, 2), sl(2'b00, 0, 4), UN, sl(2'b00, 1, 4));
        tbl[3] = cmd2(UN, sl(2'b00, 0, 6), sl(2'b01, 0, 6), sl(2'b10, 0, 6));
        for (int i = 0; i < 4; i++) run(tbl[i], 32'(i + 3), i % 3);

        // NSRC=4 instance with step_ack tied high.
        trace4.delete();
        done_cnt = 0;
        rec4 = 1;
        @(posedge clk); #1;
        bus4.cmd = {sl(2'b10, 0, 5), sl(2'b00, 1, 4), UN,
                    sl(2'b01, 0, 3), sl(2'b00, 0, 2), sl(2'b00, 0, 1)};
        bus4.start = 1;
        @(posedge clk); #1;
        bus4.start = 0;
        repeat (20) @(posedge clk);
        #1;
        rec4 = 0;
        exp_t = '{8, 16, 24, 29, 28, 36, 26, 40, 48, 56, 65, 69, 66, 72};
        check_trace("nsrc4_path", trace4);
        chk("nsrc4_cycles", trace4.size(), 14);
        chk("nsrc4_done_pulse", done_cnt, 1);
        chk("nsrc4_idle", bus4.busy, 0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
